// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: DATA_W-bit words in on valid/ready, one bit per transfer out,
// with first/last flags. Latency 1 cycle from word acceptance to first bit; a 1-entry holding register gives gap-free frames.
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic [DATA_W-1:0] hr, hr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              hr_full, hr_full_nxt;

  logic              in_fire;
  logic              bit_fire;
  logic              at_last;
  logic [DATA_W-1:0] sr_shifted;
  logic              sr_head;

  assign in_ready  = !RST && !hr_full;
  assign in_fire   = in_valid && in_ready;
  assign ser_valid = (state == SHIFT);
  assign bit_fire  = ser_valid && ser_ready;
  assign at_last   = (cnt == LAST_CNT);

  // The head of SR is always the next bit on the wire; shifting moves the next bit into it.
  assign sr_head    = MSB_FIRST ? sr[DATA_W-1] : sr[0];
  assign sr_shifted = MSB_FIRST ? {sr[DATA_W-2:0], 1'b0} : {1'b0, sr[DATA_W-1:1]};

  assign ser_bit   = ser_valid && sr_head;
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = ser_valid && at_last;
  assign busy      = ser_valid || hr_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      sr      <= '0;
      hr      <= '0;
      cnt     <= '0;
      hr_full <= 1'b0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      hr      <= hr_nxt;
      cnt     <= cnt_nxt;
      hr_full <= hr_full_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    hr_nxt      = hr;
    cnt_nxt     = cnt;
    hr_full_nxt = hr_full;

    case (state)
      IDLE: begin
        if (in_fire) begin
          sr_nxt    = in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_fire && at_last) begin
          cnt_nxt = '0;
          if (hr_full) begin
            sr_nxt      = hr;
            hr_full_nxt = 1'b0;
          end else if (in_fire) begin
            // Word arriving on the frame boundary bypasses HR straight into SR.
            sr_nxt = in_data;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (bit_fire) begin
            sr_nxt  = sr_shifted;
            cnt_nxt = cnt + CW'(1);
          end
          if (in_fire) begin
            hr_nxt      = in_data;
            hr_full_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three configurations, expected bits queued on word acceptance.
module tb_piso_serializer;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // a: DATA_W=8 MSB first; b: DATA_W=8 LSB first; c: DATA_W=4 MSB first
  logic [7:0] in_data_a, in_data_b;
  logic [3:0] in_data_c;
  logic in_valid_a, in_valid_b, in_valid_c;
  logic in_ready_a, in_ready_b, in_ready_c;
  logic ser_bit_a, ser_bit_b, ser_bit_c;
  logic ser_valid_a, ser_valid_b, ser_valid_c;
  logic ser_ready_a, ser_ready_b, ser_ready_c;
  logic ser_first_a, ser_first_b, ser_first_c;
  logic ser_last_a, ser_last_b, ser_last_c;
  logic busy_a, busy_b, busy_c;

  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  logic [2:0] q_c[$];
  int run_a = 0;
  int max_run_a = 0;

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .ser_bit(ser_bit_a), .ser_valid(ser_valid_a), .ser_ready(ser_ready_a),
    .ser_first(ser_first_a), .ser_last(ser_last_a), .busy(busy_a));

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .ser_bit(ser_bit_b), .ser_valid(ser_valid_b), .ser_ready(ser_ready_b),
    .ser_first(ser_first_b), .ser_last(ser_last_b), .busy(busy_b));

  piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1)) dut_c (
    .CLK(CLK), .RST(RST), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .ser_bit(ser_bit_c), .ser_valid(ser_valid_c), .ser_ready(ser_ready_c),
    .ser_first(ser_first_c), .ser_last(ser_last_c), .busy(busy_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each transferred bit is popped and compared as {bit, first, last}.
  always @(negedge CLK) begin
    logic [2:0] e;
    if (ser_valid_a) run_a++; else run_a = 0;
    if (run_a > max_run_a) max_run_a = run_a;
    if (!RST && ser_valid_a && ser_ready_a) begin
      check("a_expected_pending", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_bit_first_last", {ser_bit_a, ser_first_a, ser_last_a}, e);
      end
    end
    if (!RST && ser_valid_b && ser_ready_b) begin
      check("b_expected_pending", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_bit_first_last", {ser_bit_b, ser_first_b, ser_last_b}, e);
      end
    end
    if (!RST && ser_valid_c && ser_ready_c) begin
      check("c_expected_pending", q_c.size() != 0, 1);
      if (q_c.size() != 0) begin
        e = q_c.pop_front();
        check("c_bit_first_last", {ser_bit_c, ser_first_c, ser_last_c}, e);
      end
    end
  end

  // Called at posedge+1; leaves in_valid high and returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [7:0] w);
    logic got = 1'b0;
    in_data_a  = w;
    in_valid_a = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge CLK);
      if (in_ready_a) begin
        @(posedge CLK);
        #1;
        got = 1'b1;
      end
    end
    check("a_word_accepted", got, 1);
    for (int i = 0; i < 8; i++) q_a.push_back({w[7-i], i == 0, i == 7});
  endtask

  task automatic send_b(input logic [7:0] w);
    logic got = 1'b0;
    in_data_b  = w;
    in_valid_b = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge CLK);
      if (in_ready_b) begin
        @(posedge CLK);
        #1;
        got = 1'b1;
      end
    end
    check("b_word_accepted", got, 1);
    for (int i = 0; i < 8; i++) q_b.push_back({w[i], i == 0, i == 7});
  endtask

  task automatic send_c(input logic [3:0] w);
    logic got = 1'b0;
    in_data_c  = w;
    in_valid_c = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge CLK);
      if (in_ready_c) begin
        @(posedge CLK);
        #1;
        got = 1'b1;
      end
    end
    check("c_word_accepted", got, 1);
    for (int i = 0; i < 4; i++) q_c.push_back({w[3-i], i == 0, i == 3});
  endtask

  task automatic drain(input int which);
    int n = 0;
    logic pend = 1'b1;
    while (pend && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
      case (which)
        0: pend = (q_a.size() != 0) || busy_a;
        1: pend = (q_b.size() != 0) || busy_b;
        default: pend = (q_c.size() != 0) || busy_c;
      endcase
    end
    check("drained", pend, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    in_data_a = '0; in_data_b = '0; in_data_c = '0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    ser_ready_a = 1'b1; ser_ready_b = 1'b1; ser_ready_c = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_outputs", {ser_valid_a, ser_bit_a, ser_first_a, ser_last_a, busy_a}, 5'b0);
    check("rst_outputs_c", {ser_valid_c, in_ready_c, busy_c}, 3'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("in_ready_after_rst", {in_ready_a, in_ready_b, in_ready_c}, 3'b111);
    @(posedge CLK); #1;

    // T1: MSB first, single word, back to idle
    send_a(8'b10101011);
    in_valid_a = 1'b0;
    drain(0);
    check("t1_idle", {busy_a, ser_valid_a}, 2'b00);

    // T2: LSB first, first bit valid one cycle after accept
    send_b(8'b10101011);
    in_valid_b = 1'b0;
    @(negedge CLK);
    check("t2_latency", {ser_valid_b, ser_first_b}, 2'b11);
    drain(1);

    // T3: back-to-back words, no bubble, in_ready low while HR is full
    max_run_a = 0;
    send_a(8'hA5);
    send_a(8'h3C);
    in_valid_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      check("t3_in_ready_low", in_ready_a, 0);
    end
    @(negedge CLK);
    check("t3_in_ready_back", in_ready_a, 1);
    @(posedge CLK); #1;
    drain(0);
    check("t3_gap_free_run", max_run_a, 16);

    // T4: stall at bit 4 of 8'hF0
    send_a(8'hF0);
    in_valid_a = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    ser_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t4_stall_hold", {ser_valid_a, ser_bit_a, ser_first_a, ser_last_a}, 4'b1000);
    end
    @(posedge CLK); #1;
    ser_ready_a = 1'b1;
    drain(0);

    // T5: reset mid-frame with HR holding a word
    send_a(8'hFF);
    send_a(8'h00);
    in_valid_a = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    check("t5_pre_reset", {ser_valid_a, ser_bit_a, busy_a, in_ready_a}, 4'b1110);
    RST = 1'b1;
    q_a.delete();
    #1;
    check("t5_reset_outputs",
          {ser_valid_a, ser_bit_a, ser_first_a, ser_last_a, busy_a, in_ready_a}, 6'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("t5_after_release", {ser_valid_a, busy_a, in_ready_a}, 3'b001);
    @(negedge CLK);
    check("t5_no_stale_valid", ser_valid_a, 0);
    @(posedge CLK); #1;
    send_a(8'h81);
    in_valid_a = 1'b0;
    drain(0);

    // T6: DATA_W=4, two words back to back
    send_c(4'h9);
    send_c(4'h6);
    in_valid_c = 1'b0;
    drain(2);
    check("t6_idle", {busy_c, ser_valid_c}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
